// File: rtl/aes_pkg.sv
// AES key-schedule shared definitions.
// Holds the key-length encodings, FSM state type, per-length Nk/Nr lookups,
// GF(2^8) doubling (xtime) and the MAX_NR derivation used to size storage.
package aes_pkg;

  typedef enum logic [1:0] {
    KEY_LEN_128 = 2'b00,
    KEY_LEN_192 = 2'b01,
    KEY_LEN_256 = 2'b10,
    KEY_LEN_BAD = 2'b11
  } key_len_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_GEN,
    ST_DONE
  } state_e;

  // Word index width. The largest schedule is 4*(14+1) = 60 words, and even
  // the smallest (44 words) needs 6 bits, so this is fixed for all legal
  // MAX_KEY_BITS values. It also equals {round[3:0], 2'b00}.
  localparam int WORD_IDX_W = 6;

  // Rounds for the largest supported key: Nr = Nk + 6, Nk = bits / 32.
  function automatic int max_nr_of(input int key_bits);
    return key_bits / 32 + 6;
  endfunction

  function automatic logic [3:0] nk_of(input logic [1:0] len);
    case (key_len_e'(len))
      KEY_LEN_128: return 4'd4;
      KEY_LEN_192: return 4'd6;
      default:     return 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] len);
    case (key_len_e'(len))
      KEY_LEN_128: return 4'd10;
      KEY_LEN_192: return 4'd12;
      default:     return 4'd14;
    endcase
  endfunction

  // Legal encoding and not longer than the instance was built for.
  function automatic logic key_len_ok(input logic [1:0] len, input int max_bits);
    return (key_len_e'(len) != KEY_LEN_BAD) && ((128 + 64 * int'(len)) <= max_bits);
  endfunction

  // Multiply by x in GF(2^8) with the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational table lookup.
// Ports: in_byte (8b) -> out_byte (8b).
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Entry 0 occupies the top byte, so entry n sits at bit offset (255-n)*8,
  // which is simply {~n, 3'b000}.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] bit_base;

  assign bit_base = {~in_byte, 3'b000};
  assign out_byte = SBOX_TABLE[bit_base +: 8];

endmodule

// File: rtl/aes_subword.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word.
// Ports: word_in (32b) -> word_out (32b).
module aes_subword (
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte (word_in[8*b +: 8]),
      .out_byte(word_out[8*b +: 8])
    );
  end

endmodule

// File: rtl/aes_key_sched.sv
// AES key expansion (128/192/256-bit keys) with round-key read port.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, key_len, key expansion request, length code, left-aligned key
//   busy, done, err     in progress, one-cycle completion pulse, sticky reject
//   rk_rd_en, rk_rd_idx round-key read request and round number
//   rk_rd_data/valid    registered read result, one cycle after the request
// Flow: IDLE -> LOAD (write w[0..Nk-1]) -> GEN (one word per cycle) -> DONE.
module aes_key_sched
  import aes_pkg::*;
#(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [1:0]              key_len,
  input  logic [MAX_KEY_BITS-1:0] key,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  input  logic                    rk_rd_en,
  input  logic [3:0]              rk_rd_idx,
  output logic [127:0]            rk_rd_data,
  output logic                    rk_rd_valid
);

  localparam int MAX_NK = MAX_KEY_BITS / 32;
  localparam int MAX_NR = max_nr_of(MAX_KEY_BITS);
  localparam int WORDS  = 4 * (MAX_NR + 1);

  typedef logic [WORD_IDX_W-1:0] widx_t;

  state_e                  state, state_next;
  logic [MAX_KEY_BITS-1:0] key_q;
  logic [3:0]              nk_q, nr_q;
  widx_t                   i_q;       // index of the word being generated
  logic [2:0]              mod_q;     // i_q mod Nk, tracked without a divider
  logic [7:0]              rcon_q;
  logic                    key_ready;

  logic [31:0] w [WORDS];
  logic [31:0] key_words [MAX_NK];

  logic        accept, reject, last_word, rd_ok;
  logic [31:0] temp, old_word, rot_word, sub_in, sub_out, temp_mix, new_word;
  widx_t       rd_base;

  for (genvar g = 0; g < MAX_NK; g++) begin : g_key_words
    assign key_words[g] = key_q[MAX_KEY_BITS-1-32*g -: 32];
  end

  assign accept    = (state == ST_IDLE) && start && key_len_ok(key_len, MAX_KEY_BITS);
  assign reject    = (state == ST_IDLE) && start && !key_len_ok(key_len, MAX_KEY_BITS);
  // Last word index is 4*(Nr+1)-1 = {Nr, 2'b11}.
  assign last_word = (i_q == {nr_q, 2'b11});

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next; a missing branch
    // would otherwise infer a latch.
    state_next = state;
    case (state)
      ST_IDLE: if (accept)    state_next = ST_LOAD;
      ST_LOAD:                state_next = ST_GEN;
      ST_GEN:  if (last_word) state_next = ST_DONE;
      ST_DONE:                state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  // ---------------- word generation ----------------
  assign temp     = w[i_q - widx_t'(1)];
  assign old_word = w[i_q - widx_t'(nk_q)];
  assign rot_word = {temp[23:0], temp[31:24]};
  assign sub_in   = (mod_q == 3'd0) ? rot_word : temp;

  aes_subword u_subword (
    .word_in (sub_in),
    .word_out(sub_out)
  );

  always_comb begin
    temp_mix = temp;
    if (mod_q == 3'd0)                        temp_mix = sub_out ^ {rcon_q, 24'h0};
    else if (nk_q == 4'd8 && mod_q == 3'd4)   temp_mix = sub_out;
  end

  assign new_word = old_word ^ temp_mix;

  // NOTE: word storage has no reset; contents are meaningless until a
  // schedule completes and key_ready gates every read until then.
  always_ff @(posedge clk) begin
    if (state == ST_LOAD) begin
      for (int j = 0; j < MAX_NK; j++) begin
        if (j < int'(nk_q)) w[j] <= key_words[j];
      end
    end else if (state == ST_GEN) begin
      w[i_q] <= new_word;
    end
  end

  // ---------------- control / outputs ----------------
  assign rd_base = {rk_rd_idx, 2'b00};
  assign rd_ok   = rk_rd_en && key_ready && !busy && (rk_rd_idx <= nr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      key_ready   <= 1'b0;
      key_q       <= '0;
      nk_q        <= 4'd0;
      nr_q        <= 4'd0;
      i_q         <= '0;
      mod_q       <= 3'd0;
      rcon_q      <= 8'h01;
      rk_rd_valid <= 1'b0;
      rk_rd_data  <= '0;
    end else begin
      busy <= (state_next == ST_LOAD) || (state_next == ST_GEN);
      done <= (state_next == ST_DONE);

      if (accept) begin
        key_q     <= key;
        nk_q      <= nk_of(key_len);
        nr_q      <= nr_of(key_len);
        err       <= 1'b0;
        key_ready <= 1'b0;
      end else if (reject) begin
        err <= 1'b1;
      end

      // Only reachable from GEN, so never collides with accept.
      if (state_next == ST_DONE) key_ready <= 1'b1;

      case (state)
        ST_LOAD: begin
          i_q    <= widx_t'(nk_q);
          mod_q  <= 3'd0;
          rcon_q <= 8'h01;
        end
        ST_GEN: begin
          i_q   <= i_q + widx_t'(1);
          mod_q <= ({1'b0, mod_q} == nk_q - 4'd1) ? 3'd0 : mod_q + 3'd1;
          if (mod_q == 3'd0) rcon_q <= xtime(rcon_q);
        end
        default: ;
      endcase

      rk_rd_valid <= rd_ok;
      rk_rd_data  <= rd_ok ? {w[rd_base], w[rd_base + widx_t'(1)],
                              w[rd_base + widx_t'(2)], w[rd_base + widx_t'(3)]}
                           : '0;
    end
  end

endmodule

// File: tb/tb_aes_key_sched.sv
// Self-checking bench for aes_key_sched: FIPS-197 vectors through a
// 256-bit-capable instance, plus a 128-bit-only instance for length rejection.
module tb_aes_key_sched;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_a = 1'b0, start_b = 1'b0;
  logic [1:0]   key_len = 2'b00;
  logic [255:0] key = '0;
  logic         rk_rd_en = 1'b0;
  logic [3:0]   rk_rd_idx = 4'd0;

  logic         busy_a, done_a, err_a, valid_a;
  logic [127:0] data_a;
  logic         busy_b, done_b, err_b, valid_b;
  logic [127:0] data_b;

  logic         sel = 1'b0;  // 0: 256-bit instance, 1: 128-bit instance
  logic         busy_m, done_m, err_m, valid_m;
  logic [127:0] data_m;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  aes_key_sched #(.MAX_KEY_BITS(256)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .key_len(key_len), .key(key),
    .busy(busy_a), .done(done_a), .err(err_a),
    .rk_rd_en(rk_rd_en), .rk_rd_idx(rk_rd_idx),
    .rk_rd_data(data_a), .rk_rd_valid(valid_a)
  );

  aes_key_sched #(.MAX_KEY_BITS(128)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .key_len(key_len), .key(key[255:128]),
    .busy(busy_b), .done(done_b), .err(err_b),
    .rk_rd_en(rk_rd_en), .rk_rd_idx(rk_rd_idx),
    .rk_rd_data(data_b), .rk_rd_valid(valid_b)
  );

  assign busy_m  = sel ? busy_b  : busy_a;
  assign done_m  = sel ? done_b  : done_a;
  assign err_m   = sel ? err_b   : err_a;
  assign valid_m = sel ? valid_b : valid_a;
  assign data_m  = sel ? data_b  : data_a;

  typedef struct {
    logic [1:0]   len;
    logic [255:0] key;
    int           done_edge;
    logic [3:0]   r_a;
    logic [127:0] exp_a;
    logic [3:0]   r_b;
    logic [127:0] exp_b;
  } vec_t;

  vec_t vecs [3];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  task automatic do_read(input logic [3:0] idx, input logic exp_valid,
                         input logic [127:0] exp_data, input string name);
    @(negedge clk);
    rk_rd_en  = 1'b1;
    rk_rd_idx = idx;
    @(posedge clk);
    #1;
    rk_rd_en = 1'b0;
    check({name, " valid"}, 128'(valid_m), 128'(exp_valid));
    check({name, " data"}, data_m, exp_data);
  endtask

  task automatic try_start(input logic [1:0] len);
    @(negedge clk);
    key_len = len;
    set_start(1'b1);
    @(posedge clk);
    #1;
    set_start(1'b0);
  endtask

  // Start an expansion, count edges to done, read in the done cycle, and
  // optionally re-pulse start mid-GEN (it must be ignored).
  task automatic run_expand(input logic [1:0] len, input logic [255:0] k, input int exp_edge,
                            input int pulse_at, input logic [3:0] rd_r,
                            input logic [127:0] rd_exp, input string name);
    int n;
    bit seen, busy_ok;
    @(negedge clk);
    key_len = len;
    key     = k;
    set_start(1'b1);
    @(posedge clk);   // start edge (edge 0)
    #1;
    set_start(1'b0);
    n = 0; seen = 0; busy_ok = 1;
    while (!seen && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 6) begin
        check({name, " busy read valid"}, 128'(valid_m), 128'(0));
        check({name, " busy read data"}, data_m, 128'(0));
        rk_rd_en = 1'b0;
      end
      if (done_m) begin
        seen = 1;
      end else begin
        if (!busy_m) busy_ok = 0;
        set_start(pulse_at == n);
        if (n == 5) begin
          rk_rd_en  = 1'b1;
          rk_rd_idx = 4'd0;
        end
      end
    end
    check({name, " done edge"}, 128'(n), 128'(exp_edge));
    check({name, " busy until done"}, 128'(busy_ok), 128'(1));
    check({name, " busy in done cycle"}, 128'(busy_m), 128'(0));
    check({name, " err cleared"}, 128'(err_m), 128'(0));
    // Read issued and start raised during the done cycle.
    rk_rd_en  = 1'b1;
    rk_rd_idx = rd_r;
    set_start(1'b1);
    @(posedge clk);
    #1;
    rk_rd_en = 1'b0;
    set_start(1'b0);
    check({name, " done one cycle"}, 128'(done_m), 128'(0));
    check({name, " start in done ignored"}, 128'(busy_m), 128'(0));
    check({name, " done-cycle read valid"}, 128'(valid_m), 128'(1));
    check({name, " done-cycle read data"}, data_m, rd_exp);
  endtask

  initial begin
    vecs[0] = '{2'b01, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 47,
                4'd12, 128'he98ba06f448c773c8ecc720401002202,
                4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5};
    vecs[1] = '{2'b10, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 53,
                4'd14, 128'hfe4890d1e6188d0b046df344706c631e,
                4'd1,  128'h1f352c073b6108d72d9810a30914dff4};
    vecs[2] = '{2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 41,
                4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                4'd1,  128'ha0fafe1788542cb123a339392a6c7605};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 128'(busy_a), 128'(0));
    check("reset done", 128'(done_a), 128'(0));
    check("reset err", 128'(err_a), 128'(0));
    check("reset rd_valid", 128'(valid_a), 128'(0));
    check("reset rd_data", data_a, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // No schedule yet: reads are gated.
    sel = 1'b0;
    do_read(4'd0, 1'b0, 128'h0, "read before schedule");

    // Illegal key_len.
    try_start(2'b11);
    check("len 11 err", 128'(err_a), 128'(1));
    check("len 11 busy", 128'(busy_a), 128'(0));

    // FIPS-197 vectors.
    for (int v = 0; v < 3; v++) begin
      run_expand(vecs[v].len, vecs[v].key, vecs[v].done_edge, 0,
                 vecs[v].r_a, vecs[v].exp_a, $sformatf("vec%0d", v));
      do_read(vecs[v].r_b, 1'b1, vecs[v].exp_b, $sformatf("vec%0d read r%0d", v, vecs[v].r_b));
    end

    // Out-of-range rounds for the 128-bit schedule now held.
    do_read(4'd11, 1'b0, 128'h0, "r11 on 128-bit key");
    do_read(4'd15, 1'b0, 128'h0, "r15 on 128-bit key");
    do_read(4'd10, 1'b1, vecs[2].exp_a, "r10 reread");

    // Reset in the middle of GEN.
    @(negedge clk);
    key_len = 2'b10;
    key     = vecs[1].key;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (21) @(posedge clk);   // edge 21 = GEN cycle 20
    #1;
    rst_n = 1'b0;
    #1;
    check("mid-GEN reset busy", 128'(busy_a), 128'(0));
    check("mid-GEN reset done", 128'(done_a), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    do_read(4'd0, 1'b0, 128'h0, "read after mid-GEN reset");
    run_expand(vecs[2].len, vecs[2].key, 41, 0, 4'd10, vecs[2].exp_a, "after reset");

    // 128-bit-only instance: reject 256, then ignore a mid-GEN start pulse.
    sel = 1'b1;
    try_start(2'b10);
    check("max128 len 10 err", 128'(err_b), 128'(1));
    check("max128 len 10 busy", 128'(busy_b), 128'(0));
    run_expand(2'b00, vecs[2].key, 41, 10, 4'd10, vecs[2].exp_a, "max128 restart");
    do_read(4'd1, 1'b1, vecs[2].exp_b, "max128 read r1");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_key_sched.md
AES_KEY_SCHED -- requirements
Module: aes_key_sched

Interface
REQ-001 The block SHALL have parameter MAX_KEY_BITS, default 256, giving the largest supported key length; legal values are 128, 192 and 256.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to expand the key; sampled only in IDLE.
REQ-005 The block SHALL have port key_len, input, 2 bits: key length, 00=128, 01=192, 10=256, 11=illegal.
REQ-006 The block SHALL have port key, input, MAX_KEY_BITS bits: the cipher key, left-aligned, so word 0 is key[MAX-1:MAX-32].
REQ-007 The block SHALL have port busy, output, 1 bit: expansion in progress.
REQ-008 The block SHALL have port done, output, 1 bit: a one-cycle pulse when the schedule is complete.
REQ-009 The block SHALL have port err, output, 1 bit: last start was rejected; sticky until the next accepted start.
REQ-010 The block SHALL have port rk_rd_en, input, 1 bit: round-key read request.
REQ-011 The block SHALL have port rk_rd_idx, input, 4 bits: round number r to read.
REQ-012 The block SHALL have port rk_rd_data, output, 128 bits: round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}.
REQ-013 The block SHALL have port rk_rd_valid, output, 1 bit: rk_rd_data holds a valid round key this cycle.

Function
REQ-014 The state machine SHALL have states IDLE, LOAD, GEN and DONE; all outputs SHALL be registered.
REQ-015 In IDLE, start=1 with a legal key_len no larger than MAX_KEY_BITS SHALL capture key and key_len, clear err and key_ready, and go to LOAD; start=1 otherwise SHALL set err and stay in IDLE.
REQ-016 LOAD SHALL write words w[0..Nk-1] in one cycle and go to GEN, with Nk=4/6/8 and Nr=10/12/14.
REQ-017 GEN SHALL produce one word per cycle for i=Nk..4(Nr+1)-1, using temp=w[i-1].
REQ-018 In GEN, when i mod Nk==0: temp=SubWord(RotWord(temp))^{rcon,24'h0}, then rcon=xtime(rcon).
REQ-019 In GEN, when Nk==8 and i mod 8==4: temp=SubWord(temp).
REQ-020 In GEN, each step SHALL write w[i]=w[i-Nk]^temp.
REQ-021 rcon SHALL be reloaded with 8'h01 in LOAD and follow 01,02,...,80,1b,36 by GF(2^8) doubling.
REQ-022 After the last write GEN SHALL go to DONE, which SHALL pulse done for one cycle, set key_ready, and return to IDLE.
REQ-023 done SHALL be high at edge 1+(4(Nr+1)-Nk) after the start edge: 41 for 128-bit, 47 for 192-bit, 53 for 256-bit keys.
REQ-024 busy SHALL be high from the edge after start up to and excluding the done cycle.
REQ-025 start while busy or done is high SHALL be ignored, with no err.
REQ-026 A read with rk_rd_en=1, key_ready=1, busy=0 and rk_rd_idx<=Nr SHALL give rk_rd_valid=1 and rk_rd_data on the next cycle (1-cycle latency).
REQ-027 Any other read SHALL give rk_rd_valid=0 and rk_rd_data=0 on the next cycle.
REQ-028 A read issued in the same cycle as done SHALL be valid.
REQ-029 Word storage SHALL hold 4(MAX_NR+1) words, where MAX_NR follows from MAX_KEY_BITS.

Reset
REQ-030 rst_n low SHALL force IDLE at any time, including mid-GEN, and clear busy, done, err, rk_rd_valid, rk_rd_data, key_ready and the word index, and set rcon to 01.
REQ-031 Word storage need not be reset; key_ready=0 SHALL gate all reads until a new schedule completes.

Structure
REQ-032 Package aes_pkg SHALL hold the key_len encodings, the Nk/Nr lookup functions, the xtime function and the MAX_NR derivation.
REQ-033 A sub-module aes_subword SHALL wrap four existing sbox instances (32-bit in, 32-bit out); the block SHALL instantiate exactly one.

Verification
REQ-034 For key 2b7e151628aed2a6abf7158809cf4f3c, len 00: done at edge 41, and reading r=10 SHALL return d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-035 For key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, len 01: done at edge 47, and reading r=12 SHALL return e98ba06f448c773c8ecc720401002202.
REQ-036 For key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, len 10: done at edge 53, and reading r=14 SHALL return fe4890d1e6188d0b046df344706c631e.
REQ-037 Reads while busy, r=11 for a 128-bit key, and key_len=11 SHALL give rk_rd_valid=0 and data 0; key_len=11 SHALL also set err=1 with busy staying 0.
REQ-038 rst_n pulsed low at GEN cycle 20 SHALL give busy=0 and key_ready=0 immediately; a following 128-bit start SHALL still produce the correct round 10 key.
REQ-039 With MAX_KEY_BITS=128, start with len 10 SHALL give err=1; start pulsed again mid-GEN SHALL leave the done timing unchanged.
